// File: rtl/timer_pkg.sv
// Shared constants, key codes and the FSM state encoding for the IR-driven
// 4-digit up/down timer sequencer.
package timer_pkg;

  localparam int KEY_W    = 8;
  localparam int KEY_LSB  = 16;
  localparam int DIGIT_W  = 4;
  localparam int DIGITS   = 4;
  localparam int PRESET_W = DIGIT_W * DIGITS;

  localparam logic [KEY_W-1:0] KEY_CLR       = 8'h10;
  localparam logic [KEY_W-1:0] KEY_MODE      = 8'h11;
  localparam logic [KEY_W-1:0] KEY_SS        = 8'h16;
  localparam logic [KEY_W-1:0] KEY_DIGIT_MAX = 8'h09;

  localparam int HOLD_W    = 2;
  localparam int DONE_HOLD = 3;

  typedef enum logic [2:0] {
    UP_RUN    = 3'd0,
    UP_HOLD   = 3'd1,
    SET       = 3'd2,
    DOWN_RUN  = 3'd3,
    DOWN_HOLD = 3'd4,
    DONE      = 3'd5
  } state_t;

  function automatic logic is_digit_key(input logic [KEY_W-1:0] k);
    return k <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/ir_key_capture.sv
// Captures the key byte of an IR frame on the rising edge of ir_ready so a
// held level (repeat frames) yields exactly one key_valid pulse.
module ir_key_capture
  import timer_pkg::*;
(
  input  logic             clk_1HZ,
  input  logic             rst,
  input  logic             ir_ready,
  input  logic [31:0]      ir_in,
  output logic             key_valid,
  output logic [KEY_W-1:0] key
);

  logic ir_ready_d;
  logic rise;
  logic unused_frame_bits;

  assign rise              = ir_ready & ~ir_ready_d;
  assign unused_frame_bits = ^{ir_in[31:KEY_LSB+KEY_W], ir_in[KEY_LSB-1:0]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_1HZ or negedge rst) begin
    if (!rst) begin
      ir_ready_d <= 1'b0;
      key_valid  <= 1'b0;
      key        <= '0;
    end else begin
      ir_ready_d <= ir_ready;
      key_valid  <= rise;
      if (rise) key <= ir_in[KEY_LSB +: KEY_W];
    end
  end

endmodule

// File: rtl/timer_cmd_sequencer.sv
// Mode/run/hold FSM and BCD preset register driving the timer datapath.
// Build option AUTO_RELOAD_EN: countdown expiry reloads the preset and keeps running.
module timer_cmd_sequencer
  import timer_pkg::*;
(
  input  logic                clk_1HZ,
  input  logic                rst,
  input  logic                ir_ready,
  input  logic [31:0]         ir_in,
  input  logic                cnt_zero,
  output logic                cnt_load,
  output logic                cnt_en,
  output logic                cnt_dir,
  output logic [PRESET_W-1:0] preset,
  output logic                done_pulse,
  output logic [2:0]          state
);

  state_t              cur_state, next_state;
  logic [PRESET_W-1:0] preset_q, preset_d;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                load_q, load_d, done_q, done_d, en_q, en_d, dir_q, dir_d;
  logic                key_valid;
  logic [KEY_W-1:0]    key;
  logic                is_mode, is_ss, is_clr, is_digit, expiry;

  ir_key_capture u_capture (
    .clk_1HZ  (clk_1HZ),
    .rst      (rst),
    .ir_ready (ir_ready),
    .ir_in    (ir_in),
    .key_valid(key_valid),
    .key      (key)
  );

  assign is_mode  = key_valid && (key == KEY_MODE);
  assign is_ss    = key_valid && (key == KEY_SS);
  assign is_clr   = key_valid && (key == KEY_CLR);
  assign is_digit = key_valid && is_digit_key(key);
  // cnt_zero is stale during the load cycle, so expiry waits for the new count.
  assign expiry   = (cur_state == DOWN_RUN) && cnt_zero && !load_q;

  always_ff @(posedge clk_1HZ or negedge rst) begin
    if (!rst) begin
      cur_state <= UP_RUN;
      preset_q  <= '0;
      hold_cnt  <= '0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      cur_state <= next_state;
      preset_q  <= preset_d;
      hold_cnt  <= (cur_state == DONE) ? hold_cnt + 1'b1 : '0;
      load_q    <= load_d;
      done_q    <= done_d;
      en_q      <= en_d;
      dir_q     <= dir_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = cur_state;
    if (is_mode) begin
      next_state = (cur_state == SET) ? UP_RUN : SET;
    end else begin
      case (cur_state)
        UP_RUN:    if (is_ss) next_state = UP_HOLD;
        UP_HOLD:   if (is_ss) next_state = UP_RUN;
        SET:       if (is_ss && preset_q != '0) next_state = DOWN_RUN;
        DOWN_RUN: begin
          if (expiry) begin
`ifdef AUTO_RELOAD_EN
            next_state = DOWN_RUN;
`else
            next_state = DONE;
`endif
          end else if (is_ss) begin
            next_state = DOWN_HOLD;
          end
        end
        DOWN_HOLD: begin
          if (is_ss)       next_state = DOWN_RUN;
          else if (is_clr) next_state = SET;
        end
        DONE:      if (hold_cnt == HOLD_W'(DONE_HOLD - 1)) next_state = SET;
        default:   next_state = UP_RUN;
      endcase
    end
  end

  always_comb begin
    preset_d = preset_q;
    load_d   = 1'b0;
    done_d   = 1'b0;
    if (is_mode) begin
      if (cur_state == SET) begin
        preset_d = '0;
        load_d   = 1'b1;
      end
    end else begin
      case (cur_state)
        UP_HOLD: if (is_clr) begin
          preset_d = '0;
          load_d   = 1'b1;
        end
        SET: begin
          if (is_digit)                       preset_d = {preset_q[PRESET_W-DIGIT_W-1:0], key[DIGIT_W-1:0]};
          else if (is_clr)                    preset_d = '0;
          else if (is_ss && preset_q != '0)   load_d   = 1'b1;
        end
        DOWN_RUN: if (expiry) begin
          done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
          load_d = 1'b1;
`endif
        end
        DOWN_HOLD: if (is_clr) preset_d = '0;
        default: ;
      endcase
    end
    en_d  = ((next_state == UP_RUN) || (next_state == DOWN_RUN)) && !load_d;
    dir_d = !((next_state == UP_RUN) || (next_state == UP_HOLD));
  end

  assign state      = cur_state;
  assign preset     = preset_q;
  assign cnt_load   = load_q;
  assign done_pulse = done_q;
  assign cnt_dir    = dir_q;
  assign cnt_en     = en_q && !expiry;

endmodule

// File: tb/tb_timer_cmd_sequencer.sv
// Directed self-checking bench for timer_cmd_sequencer; inputs change and
// outputs are sampled on the falling clock edge.
module tb_timer_cmd_sequencer;
  import timer_pkg::*;

  logic        clk_1HZ = 1'b0;
  logic        rst;
  logic        ir_ready;
  logic [31:0] ir_in;
  logic        cnt_zero;
  logic        cnt_load, cnt_en, cnt_dir, done_pulse;
  logic [15:0] preset;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  timer_cmd_sequencer dut (
    .clk_1HZ   (clk_1HZ),
    .rst       (rst),
    .ir_ready  (ir_ready),
    .ir_in     (ir_in),
    .cnt_zero  (cnt_zero),
    .cnt_load  (cnt_load),
    .cnt_en    (cnt_en),
    .cnt_dir   (cnt_dir),
    .preset    (preset),
    .done_pulse(done_pulse),
    .state     (state)
  );

  always #5 clk_1HZ = ~clk_1HZ;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One key press: rising edge, capture, then the key acts; ends on a falling edge.
  task automatic press(input logic [7:0] k);
    ir_in    = {8'hA5, k, 16'h5A3C};
    ir_ready = 1'b1;
    @(negedge clk_1HZ);
    ir_ready = 1'b0;
    @(negedge clk_1HZ);
  endtask

  initial begin
    rst      = 1'b1;
    ir_ready = 1'b0;
    ir_in    = '0;
    cnt_zero = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_state",  32'(state),      32'(UP_RUN));
    check("rst_en",     32'(cnt_en),     32'd0);
    check("rst_load",   32'(cnt_load),   32'd0);
    check("rst_dir",    32'(cnt_dir),    32'd0);
    check("rst_preset", 32'(preset),     32'd0);
    check("rst_done",   32'(done_pulse), 32'd0);
    @(negedge clk_1HZ);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk_1HZ);
      check("idle_state", 32'(state),    32'(UP_RUN));
      check("idle_en",    32'(cnt_en),   32'd1);
      check("idle_load",  32'(cnt_load), 32'd0);
    end

    // Held ir_ready: four cycles of repeat frames toggle start/stop only once.
    ir_in    = {8'h00, KEY_SS, 16'h0000};
    ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk_1HZ);
    ir_ready = 1'b0;
    @(negedge clk_1HZ);
    check("hold_state", 32'(state),   32'(UP_HOLD));
    check("hold_en",    32'(cnt_en),  32'd0);
    check("hold_dir",   32'(cnt_dir), 32'd0);

    press(KEY_MODE);
    check("set_state", 32'(state),   32'(SET));
    check("set_dir",   32'(cnt_dir), 32'd1);
    check("set_en",    32'(cnt_en),  32'd0);
    press(8'h01); press(8'h02); press(8'h03); press(8'h04); press(8'h05);
    check("preset_2345", 32'(preset), 32'h2345);
    press(8'h0A);
    press(8'h13);
    check("preset_ignore", 32'(preset), 32'h2345);

    press(KEY_SS);
    check("ss_load",  32'(cnt_load), 32'd1);
    check("ss_state", 32'(state),    32'(DOWN_RUN));
    check("ss_en",    32'(cnt_en),   32'd0);
    @(negedge clk_1HZ);
    check("dr_load", 32'(cnt_load), 32'd0);
    check("dr_en",   32'(cnt_en),   32'd1);
    check("dr_dir",  32'(cnt_dir),  32'd1);

    // Expiry and start/stop land together; expiry must win.
    ir_in    = {8'h00, KEY_SS, 16'h0000};
    ir_ready = 1'b1;
    @(negedge clk_1HZ);
    ir_ready = 1'b0;
    cnt_zero = 1'b1;
    #1 check("zero_en_mask", 32'(cnt_en), 32'd0);
    @(negedge clk_1HZ);
    cnt_zero = 1'b0;
    check("done_pulse", 32'(done_pulse), 32'd1);
    check("done_state", 32'(state),      32'(DONE));
    check("done_en",    32'(cnt_en),     32'd0);
    @(negedge clk_1HZ);
    check("done_pulse_1cyc", 32'(done_pulse), 32'd0);
    check("done_state_c1",   32'(state),      32'(DONE));
    @(negedge clk_1HZ);
    check("done_state_c2", 32'(state), 32'(DONE));
    @(negedge clk_1HZ);
    check("done_to_set",  32'(state),  32'(SET));
    check("done_preset",  32'(preset), 32'h2345);

    press(KEY_CLR);
    check("clr_preset", 32'(preset), 32'd0);
    press(KEY_SS);
    check("ss0_state", 32'(state),    32'(SET));
    check("ss0_load",  32'(cnt_load), 32'd0);

    press(8'h07);
    press(KEY_SS);
    check("ss7_state", 32'(state), 32'(DOWN_RUN));
    press(KEY_SS);
    check("dh_state", 32'(state),  32'(DOWN_HOLD));
    check("dh_en",    32'(cnt_en), 32'd0);
    press(KEY_CLR);
    check("dh_clr_state",  32'(state),  32'(SET));
    check("dh_clr_preset", 32'(preset), 32'd0);

    // MODE beats a simultaneous expiry.
    press(8'h09);
    press(KEY_SS);
    @(negedge clk_1HZ);
    ir_in    = {8'h00, KEY_MODE, 16'h0000};
    ir_ready = 1'b1;
    @(negedge clk_1HZ);
    ir_ready = 1'b0;
    cnt_zero = 1'b1;
    @(negedge clk_1HZ);
    cnt_zero = 1'b0;
    check("mode_pri_state",  32'(state),      32'(SET));
    check("mode_pri_done",   32'(done_pulse), 32'd0);
    check("mode_pri_preset", 32'(preset),     32'h0009);

    press(KEY_MODE);
    check("set_up_state",  32'(state),    32'(UP_RUN));
    check("set_up_load",   32'(cnt_load), 32'd1);
    check("set_up_preset", 32'(preset),   32'd0);
    check("set_up_en",     32'(cnt_en),   32'd0);
    @(negedge clk_1HZ);
    check("up_en",  32'(cnt_en),  32'd1);
    check("up_dir", 32'(cnt_dir), 32'd0);

    press(KEY_SS);
    press(KEY_CLR);
    check("uh_clr_load",  32'(cnt_load), 32'd1);
    check("uh_clr_state", 32'(state),    32'(UP_HOLD));
    check("uh_clr_en",    32'(cnt_en),   32'd0);

`ifdef AUTO_RELOAD_EN
    press(KEY_MODE);
    press(8'h03);
    check("ar_preset", 32'(preset), 32'h0003);
    press(KEY_SS);
    @(negedge clk_1HZ);
    cnt_zero = 1'b1;
    @(negedge clk_1HZ);
    cnt_zero = 1'b0;
    check("ar_done",  32'(done_pulse), 32'd1);
    check("ar_load",  32'(cnt_load),   32'd1);
    check("ar_state", 32'(state),      32'(DOWN_RUN));
    @(negedge clk_1HZ);
    check("ar_en",     32'(cnt_en),     32'd1);
    check("ar_done_0", 32'(done_pulse), 32'd0);
`endif

    // Asynchronous reset in the middle of a countdown.
    press(KEY_MODE);
    press(8'h03);
    press(KEY_SS);
    @(negedge clk_1HZ);
    #2 rst = 1'b0;
    #1;
    check("mrst_state",  32'(state),      32'(UP_RUN));
    check("mrst_en",     32'(cnt_en),     32'd0);
    check("mrst_load",   32'(cnt_load),   32'd0);
    check("mrst_dir",    32'(cnt_dir),    32'd0);
    check("mrst_preset", 32'(preset),     32'd0);
    cnt_zero = 1'b1;
    @(negedge clk_1HZ);
    check("mrst_done", 32'(done_pulse), 32'd0);
    rst      = 1'b1;
    cnt_zero = 1'b0;
    @(negedge clk_1HZ);
    check("post_rst_state", 32'(state),  32'(UP_RUN));
    check("post_rst_en",    32'(cnt_en), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
